// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit paths.
//   DEF_BIT_CYCLES : default clock cycles per bit (100 MHz / 9600 baud)
//   DATA_BITS      : payload bits per frame
//   rx_state_e     : receiver FSM state encoding
//   half_of()      : mid-bit offset helper (integer halving)
// Optional feature macro used by the receiver: UART_RX_PARITY_EN (8E1 framing).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEF_BIT_CYCLES = 10417;
    localparam int DATA_BITS      = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Offset from a bit edge to its centre.
    function automatic int half_of(input int cycles);
        return cycles / 2;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Loadable cycle counter. Counts 0..limit_i-1; tick_o is high on the cycle the
// count equals limit_i-1, after which the count restarts from zero. clr_i
// holds the count at zero and suppresses tick_o.
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   clr_i    : synchronous clear (count forced to 0, no tick)
//   limit_i  : period in cycles (must be >= 1)
//   tick_o   : one-cycle event at count == limit_i-1
// -----------------------------------------------------------------------------
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int MAX_CYCLES = DEF_BIT_CYCLES,
    parameter int CW         = $clog2(MAX_CYCLES + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic [CW-1:0] limit_i,
    output logic          tick_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = !clr_i && (cnt_q == (limit_i - CW'(1)));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Byte-level UART receiver. Synchronises the serial line, detects the start
// bit on a falling edge, samples every following bit at its centre and
// presents each correctly framed byte with a one-cycle valid strobe. Framing
// errors are reported with a separate one-cycle strobe.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset (0 = reset)
//   din        : serial line, idle high, asynchronous to clk
//   data[7:0]  : last correctly framed byte (LSB received first)
//   valid      : one-cycle pulse, data updated on the same cycle
//   frame_err  : one-cycle pulse on bad stop bit (or bad parity)
//   busy       : high from start detection until return to IDLE
// Configuration macro:
//   UART_RX_PARITY_EN : when defined the frame is 8E1 (even parity bit
//                       between data and stop); otherwise plain 8N1.
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES  = DEF_BIT_CYCLES,
    parameter int HALF_CYCLES = half_of(BIT_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(BIT_CYCLES + 1);

    // ------------------------------------------------------------------
    // Input synchroniser and edge detector. All three flops reset to the
    // idle line level so that reset release never looks like a start bit.
    // ------------------------------------------------------------------
    logic sync1_q;
    logic din_s_q;
    logic din_s_dly_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            din_s_q     <= 1'b1;
            din_s_dly_q <= 1'b1;
        end else begin
            sync1_q     <= din;
            din_s_q     <= sync1_q;
            din_s_dly_q <= din_s_q;
        end
    end

    logic fall_edge;
    assign fall_edge = din_s_dly_q && !din_s_q;

    // ------------------------------------------------------------------
    // Bit timer. It is held clear while idle, so every frame starts timing
    // from zero on the cycle START is entered. Every later state change
    // happens on a tick, which clears the count by itself.
    // ------------------------------------------------------------------
    rx_state_e     state_q;
    logic [CW-1:0] limit;
    logic          timer_clr;
    logic          sample;

    assign timer_clr = (state_q == IDLE);
    assign limit     = (state_q == START) ? CW'(HALF_CYCLES) : CW'(BIT_CYCLES);

    uart_bit_timer #(
        .MAX_CYCLES (BIT_CYCLES),
        .CW         (CW)
    ) u_timer (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (timer_clr),
        .limit_i (limit),
        .tick_o  (sample)
    );

    // ------------------------------------------------------------------
    // Receive FSM with registered outputs.
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] shreg_q;
    logic [2:0]           bit_idx_q;
    logic [7:0]           data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 busy_q;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle by default.
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (fall_edge) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (sample) begin
                        if (din_s_q) begin
                            // Line went back high before mid start bit:
                            // treat as noise.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                            perr_q    <= 1'b0;
`endif
                        end
                    end
                end

                DATA: begin
                    if (sample) begin
                        shreg_q[bit_idx_q] <= din_s_q;
                        bit_idx_q          <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        // Even parity: the parity bit equals the XOR of
                        // the eight data bits.
                        perr_q  <= (din_s_q != ^shreg_q);
                        state_q <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (sample) begin
                        // Returning to IDLE at mid-stop leaves half a bit
                        // of margin for a back-to-back start edge.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        if (din_s_q && !perr_q) begin
`else
                        if (din_s_q) begin
`endif
                            data_q  <= shreg_q;
                            valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_sampler
// Directed bench for uart_rx_sampler with BIT_CYCLES=16 (HALF_CYCLES=8).
// Define UART_RX_PARITY_EN to exercise the 8E1 build.
// -----------------------------------------------------------------------------
module tb_uart_rx_sampler;

    localparam int BC = 16;
    localparam int HC = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS_AFTER_START = 10;
`else
    localparam int NBITS_AFTER_START = 9;
`endif
    localparam int LAT = HC + NBITS_AFTER_START * BC + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx_sampler #(
        .BIT_CYCLES  (BC),
        .HALF_CYCLES (HC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    int         vcnt = 0;
    int         fcnt = 0;
    int         both = 0;
    int         vcyc = 0;
    logic [7:0] vlog [0:31];

    always @(negedge clk) begin
        if (valid) begin
            vlog[vcnt[4:0]] <= data;
            vcnt            <= vcnt + 1;
            vcyc            <= cyc;
        end
        if (frame_err) fcnt <= fcnt + 1;
        if (valid && frame_err) both <= both + 1;
    end

    int pass_cnt = 0;
    int total    = 0;
    int fall_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called aligned to posedge+#1; returns aligned the same way.
    task automatic drive_bit(input logic b);
        din = b;
        repeat (BC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_bit);
        $display("frame sent: byte=%02h stop=%0b", d, stop_bit);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(1'b1);
        $display("frame sent: byte=%02h parity=%0b", d, par);
    endtask
`endif

    int v0;
    int f0;

    initial begin
        // ---------------- reset ----------------
        rst = 1'b0;
        din = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_data",  data,      8'h00);
        check("rst_valid", valid,     1'b0);
        check("rst_ferr",  frame_err, 1'b0);
        check("rst_busy",  busy,      1'b0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // ---------------- A5 with latency ----------------
        send_frame(8'hA5, 1'b1);
        check("a5_vcnt", vcnt, 1);
        check("a5_data", data, 8'hA5);
        check("a5_ferr", fcnt, 0);
        check("a5_busy", busy, 1'b0);
        check("a5_lat_in_window",
              ((vcyc - fall_cyc) >= LAT - 1) && ((vcyc - fall_cyc) <= LAT + 1), 1'b1);
        repeat (10) @(posedge clk);
        #1;

        // ---------------- back-to-back 00, FF, 55 ----------------
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_vcnt", vcnt, 4);
        check("b2b_d0",   vlog[1], 8'h00);
        check("b2b_d1",   vlog[2], 8'hFF);
        check("b2b_d2",   vlog[3], 8'h55);
        check("b2b_ferr", fcnt, 0);

        // ---------------- framing error ----------------
        send_frame(8'h3C, 1'b0);
        check("fe_fcnt", fcnt, 1);
        check("fe_vcnt", vcnt, 4);
        check("fe_data", data, 8'h55);
        // Line held low after the error must not start a new frame.
        repeat (40) @(posedge clk);
        #1;
        check("fe_low_busy", busy, 1'b0);
        check("fe_low_fcnt", fcnt, 1);
        din = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // ---------------- 5-cycle glitch ----------------
        din = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        din = 1'b1;
        check("gl_busy_hi", busy, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("gl_busy_lo", busy, 1'b0);
        check("gl_vcnt", vcnt, 4);
        check("gl_fcnt", fcnt, 1);
        $display("glitch applied: 5 cycles low");

        // ---------------- reset abort during bit 4 of C3 ----------------
        v0 = vcnt;
        f0 = fcnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(logic'((8'hC3 >> i) & 8'h01));
        din = 1'b0;                       // bit 4 of C3
        repeat (HC) @(posedge clk);
        #1;
        check("ab_busy_pre", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("ab_busy_async", busy, 1'b0);
        check("ab_data_async", data, 8'h00);
        din = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (BC * 8) @(posedge clk);
        #1;
        check("ab_vcnt", vcnt, v0);
        check("ab_fcnt", fcnt, f0);
        $display("reset abort of byte c3");
        send_frame(8'h81, 1'b1);
        check("ab_81_vcnt", vcnt, v0 + 1);
        check("ab_81_data", data, 8'h81);

`ifdef UART_RX_PARITY_EN
        // ---------------- parity ----------------
        repeat (10) @(posedge clk);
        #1;
        v0 = vcnt;
        f0 = fcnt;
        send_frame_par(8'h07, 1'b1);
        check("par_ok_vcnt", vcnt, v0 + 1);
        check("par_ok_data", data, 8'h07);
        check("par_ok_fcnt", fcnt, f0);
        repeat (10) @(posedge clk);
        #1;
        send_frame(8'h81, 1'b1);
        check("par_81_data", data, 8'h81);
        repeat (10) @(posedge clk);
        #1;
        send_frame_par(8'h07, 1'b0);
        check("par_bad_fcnt", fcnt, f0 + 1);
        check("par_bad_vcnt", vcnt, v0 + 2);
        check("par_bad_data", data, 8'h81);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("never_both", both, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
